// File: rtl/q8_27_pkg.sv
// Q8.27 fixed-point types and limits shared by the saturating adder and subtractor.
package q8_27_pkg;

  localparam int unsigned Q_W    = 35;
  localparam int unsigned FRAC_W = 27;

  typedef logic signed [Q_W-1:0] q8_27_t;

  localparam q8_27_t Q_MAX = 35'sh3_FFFF_FFFF;
  localparam q8_27_t Q_MIN = 35'sh4_0000_0000;

endpackage

// File: rtl/q8_27_sat.sv
// Combinational clamp of a sign-extended EXT_W-bit value into Q8.27, flagging overload.
module q8_27_sat
  import q8_27_pkg::*;
#(
  parameter int unsigned EXT_W = 48
) (
  input  logic [EXT_W-1:0] raw,
  output q8_27_t           diff,
  output logic             ovl
);

  localparam int unsigned HI_W = EXT_W - Q_W + 1;

  logic [HI_W-1:0] hi;

  // In range only when every bit from the Q8.27 sign bit upward agrees.
  always_comb begin
    hi  = raw[EXT_W-1:Q_W-1];
    ovl = !((&hi) || !(|hi));
    if (ovl) begin
      diff = raw[EXT_W-1] ? Q_MIN : Q_MAX;
    end else begin
      diff = $signed(raw[Q_W-1:0]);
    end
  end

endmodule

// File: rtl/subtractor_q8_27_stream.sv
// Two-stage valid/ready saturating Q8.27 subtractor (diff = a - b) with sticky overload.
// Optional saturating overflow counter enabled by `SUB_Q8_27_OVF_CNT_EN.
module subtractor_q8_27_stream
  import q8_27_pkg::*;
#(
  parameter int unsigned EXT_W = 48,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  q8_27_t           a,
  input  q8_27_t           b,
  output logic             out_valid,
  input  logic             out_ready,
  output q8_27_t           diff,
  output logic             overload,
  output logic             ovf_sticky,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam int unsigned PAD_W = EXT_W - Q_W;

  logic             s1_valid;
  logic [EXT_W-1:0] s1_raw;
  logic [EXT_W-1:0] raw_next;
  logic             adv1;
  logic             adv2;
  q8_27_t           sat_diff;
  logic             sat_ovl;
  logic             deliver_ovl;

  assign adv2        = !out_valid || out_ready;
  assign adv1        = !s1_valid || adv2;
  assign in_ready    = adv1 && !rst;
  assign raw_next    = {{PAD_W{a[Q_W-1]}}, a} - {{PAD_W{b[Q_W-1]}}, b};
  assign deliver_ovl = out_valid && out_ready && overload;

  q8_27_sat #(.EXT_W(EXT_W)) u_sat (
    .raw  (s1_raw),
    .diff (sat_diff),
    .ovl  (sat_ovl)
  );

  // S1 holds the raw wide difference, S2 the clamped result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_raw    <= '0;
      out_valid <= 1'b0;
      diff      <= '0;
      overload  <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= in_valid;
        if (in_valid) s1_raw <= raw_next;
      end
      if (adv2) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          diff     <= sat_diff;
          overload <= sat_ovl;
        end
      end
    end
  end

  // A clamped result handed off in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (deliver_ovl) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

`ifdef SUB_Q8_27_OVF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt <= '0;
    end else if (ovf_clr) begin
      ovf_cnt <= deliver_ovl ? CNT_W'(1) : '0;
    end else if (deliver_ovl && !(&ovf_cnt)) begin
      ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end
`else
  assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_subtractor_q8_27_stream.sv
// Bench for subtractor_q8_27_stream: vector table, stall/reset sequences, random scoreboard.
module tb_subtractor_q8_27_stream;
  import q8_27_pkg::*;

  localparam int unsigned CNT_W = 16;
`ifdef SUB_Q8_27_OVF_CNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  q8_27_t           a;
  q8_27_t           b;
  logic             out_valid;
  logic             out_ready;
  q8_27_t           diff;
  logic             overload;
  logic             ovf_sticky;
  logic             ovf_clr;
  logic [CNT_W-1:0] ovf_cnt;

  int tests = 0;
  int fails = 0;

  subtractor_q8_27_stream #(.EXT_W(48), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .overload   (overload),
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr),
    .ovf_cnt    (ovf_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    q8_27_t x;
    q8_27_t y;
    q8_27_t ed;
    logic   eo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: exact integer difference, then clamp to the Q8.27 range.
  task automatic model(input q8_27_t x, input q8_27_t y, output q8_27_t d, output logic o);
    longint t;
    t = longint'(x) - longint'(y);
    o = 1'b0;
    if (t > longint'(Q_MAX)) begin
      d = Q_MAX; o = 1'b1;
    end else if (t < longint'(Q_MIN)) begin
      d = Q_MIN; o = 1'b1;
    end else begin
      d = q8_27_t'(t);
    end
  endtask

  // One isolated pair with out_ready=1: checks 2-cycle latency and the result.
  task automatic send_one(input q8_27_t x, input q8_27_t y, input q8_27_t ed, input logic eo,
                          input logic clr_at_out, input string tag);
    @(negedge clk);
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check({tag, " latency1 out_valid"}, 64'(out_valid), 64'(0));
    @(posedge clk); @(negedge clk);
    check({tag, " out_valid"}, 64'(out_valid), 64'(1));
    check({tag, " diff"}, diff, ed);
    check({tag, " overload"}, 64'(overload), 64'(eo));
    ovf_clr = clr_at_out;
    @(posedge clk); @(negedge clk);
    ovf_clr = 1'b0;
  endtask

  vec_t   vecs[11];
  q8_27_t qd[$];
  logic   qo[$];

  initial begin
    q8_27_t      ed, held, pd;
    logic        eo, po, acc, stall_prev;
    int          idx, sent, got;
    int unsigned r0, r1, r2, r3;
    q8_27_t      pa[3];
    q8_27_t      pb[3];

    vecs[0]  = '{35'sh0_0C00_0000, 35'sh0_0200_0000, 35'sh0_0A00_0000, 1'b0};
    vecs[1]  = '{35'sh0,           Q_MIN,            Q_MAX,            1'b1};
    vecs[2]  = '{Q_MIN,            35'sh1,           Q_MIN,            1'b1};
    vecs[3]  = '{Q_MAX,            Q_MAX,            35'sh0,           1'b0};
    vecs[4]  = '{Q_MIN,            Q_MIN,            35'sh0,           1'b0};
    vecs[5]  = '{35'sh5_1234_5678, 35'sh5_1234_5678, 35'sh0,           1'b0};
    vecs[6]  = '{Q_MAX,            Q_MIN,            Q_MAX,            1'b1};
    vecs[7]  = '{Q_MIN,            Q_MAX,            Q_MIN,            1'b1};
    vecs[8]  = '{35'sh7_FFFF_FFFF, Q_MAX,            Q_MIN,            1'b0};
    vecs[9]  = '{35'sh0,           Q_MAX,            35'sh4_0000_0001, 1'b0};
    vecs[10] = '{35'sh0_0200_0000, 35'sh0_0C00_0000, 35'sh7_F600_0000, 1'b0};

    rst = 1'b1; in_valid = 1'b1; a = '0; b = '0; out_ready = 1'b1; ovf_clr = 1'b0;
    #1;
    check("reset out_valid", 64'(out_valid), 64'(0));
    check("reset diff", diff, 35'sh0);
    check("reset overload", 64'(overload), 64'(0));
    check("reset ovf_sticky", 64'(ovf_sticky), 64'(0));
    check("reset ovf_cnt", 64'(ovf_cnt), 64'(0));
    check("reset in_ready", 64'(in_ready), 64'(0));
    in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++)
      send_one(vecs[i].x, vecs[i].y, vecs[i].ed, vecs[i].eo, 1'b0, $sformatf("vec%0d", i));
    check("sticky after table", 64'(ovf_sticky), 64'(1));

    // Clear without a clamped hand-off, then count clamped results.
    ovf_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    ovf_clr = 1'b0;
    check("sticky cleared", 64'(ovf_sticky), 64'(0));
    check("cnt cleared", 64'(ovf_cnt), 64'(0));
    for (int i = 0; i < 3; i++) send_one(35'sh0, Q_MIN, Q_MAX, 1'b1, 1'b0, "cnt");
    check("cnt after 3", 64'(ovf_cnt), 64'(CNT_EN * 3));
    check("sticky after 3", 64'(ovf_sticky), 64'(1));
    send_one(Q_MIN, 35'sh1, Q_MIN, 1'b1, 1'b1, "cnt clr");
    check("cnt clr+inc", 64'(ovf_cnt), 64'(CNT_EN));
    check("sticky clr+set", 64'(ovf_sticky), 64'(1));

    // Backpressure: with out_ready low only two pairs fit.
    pa[0] = 35'sh0_0C00_0000; pb[0] = 35'sh0_0200_0000;
    pa[1] = Q_MIN;            pb[1] = 35'sh1;
    pa[2] = 35'sh0_1000_0000; pb[2] = 35'sh0_0800_0000;
    @(negedge clk);
    out_ready = 1'b0; idx = 0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 3) begin
        in_valid = 1'b1; a = pa[idx]; b = pb[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
    end
    check("bp accepted", 64'(idx), 64'(2));
    check("bp in_ready", 64'(in_ready), 64'(0));
    check("bp out_valid", 64'(out_valid), 64'(1));
    check("bp diff0", diff, 35'sh0_0A00_0000);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("bp out_valid1", 64'(out_valid), 64'(1));
    check("bp diff1", diff, Q_MIN);
    check("bp ovl1", 64'(overload), 64'(1));
    @(posedge clk); @(negedge clk);
    check("bp drained", 64'(out_valid), 64'(0));

    // Random stream with random backpressure against the reference queue.
    sent = 0; got = 0; stall_prev = 1'b0; held = '0;
    for (int cyc = 0; cyc < 3000 && got < 100; cyc++) begin
      r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
      a = q8_27_t'({r1[2:0], r0});
      b = q8_27_t'({r3[2:0], r2});
      if (r1[9:8] == 2'b00) a = r1[10] ? Q_MAX : Q_MIN;
      if (r3[9:8] == 2'b00) b = r3[10] ? Q_MAX : Q_MIN;
      in_valid  = (sent < 100) && ($urandom_range(1, 0) == 1);
      out_ready = ($urandom_range(1, 0) == 1);
      #1;
      if (stall_prev) begin
        check("stall out_valid held", 64'(out_valid), 64'(1));
        check("stall diff held", diff, held);
      end
      if (out_valid && out_ready) begin
        if (qd.size() == 0) begin
          tests++; fails++;
          $display("FAIL rand extra output: got %h, expected none", diff);
        end else begin
          pd = qd.pop_front(); po = qo.pop_front();
          check($sformatf("rand diff %0d", got), diff, pd);
          check($sformatf("rand ovl %0d", got), 64'(overload), 64'(po));
        end
        got++;
      end
      stall_prev = out_valid && !out_ready;
      held = diff;
      if (in_valid && in_ready) begin
        model(a, b, ed, eo);
        qd.push_back(ed); qo.push_back(eo);
        sent++;
      end
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("rand sent", 64'(sent), 64'(100));
    check("rand received", 64'(got), 64'(100));
    check("rand leftover", 64'(qd.size()), 64'(0));

    // Reset in the middle of a full pipeline.
    @(negedge clk);
    a = 35'sh0; b = Q_MIN; in_valid = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre-rst sticky", 64'(ovf_sticky), 64'(1));
    check("pre-rst out_valid", 64'(out_valid), 64'(1));
    rst = 1'b1;
    #1;
    check("mid-rst out_valid", 64'(out_valid), 64'(0));
    check("mid-rst diff", diff, 35'sh0);
    check("mid-rst sticky", 64'(ovf_sticky), 64'(0));
    check("mid-rst cnt", 64'(ovf_cnt), 64'(0));
    check("mid-rst in_ready", 64'(in_ready), 64'(0));
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    send_one(35'sh0_0C00_0000, 35'sh0_0200_0000, 35'sh0_0A00_0000, 1'b0, 1'b0, "post-rst");
    check("post-rst sticky", 64'(ovf_sticky), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
